// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared states and SHA-256 constants for the nonce scheduler
package bitcoin_pkg;
  typedef enum logic [2:0] {IDLE, READ, MID, BLK1, BLK2, WRITE} state_t;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_640 = 32'd640;
  localparam logic [31:0] LEN_256 = 32'd256;
  localparam int HDR_WORDS = 19;
endpackage

// File: rtl/bitcoin_nonce_sched_if.sv
// bitcoin_nonce_sched_if: memory port and SHA-256 core handshake bundle
interface bitcoin_nonce_sched_if;
  logic mem_clk;
  logic [15:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic core_start;
  logic [255:0] core_hin;
  logic [511:0] core_block;
  logic core_done;
  logic [255:0] core_hout;
  modport master(
    output mem_clk, mem_addr, mem_we, mem_write_data, core_start, core_hin, core_block,
    input mem_read_data, core_done, core_hout
  );
  modport slave(
    input mem_clk, mem_addr, mem_we, mem_write_data, core_start, core_hin, core_block,
    output mem_read_data, core_done, core_hout
  );
endinterface

// File: rtl/bitcoin_block_fmt.sv
// bitcoin_block_fmt: builds the padded 512-bit message block for each core pass
module bitcoin_block_fmt
  import bitcoin_pkg::*;
(
  input  state_t                      phase,
  input  logic [HDR_WORDS-1:0][31:0]  hdr,
  input  logic [31:0]                 nonce,
  input  logic [255:0]                d1,
  output logic [511:0]                block
);
  logic [511:0] first;
  // header words 0..15 laid out word 0 first for the midstate pass
  always_comb begin
    first = '0;
    for (int i = 0; i < 16; i++) first[511-32*i -: 32] = hdr[i];
  end
  assign block = phase == BLK2 ? {d1, PAD_WORD, 192'd0, LEN_256} :
                 phase == BLK1 ? {hdr[16], hdr[17], hdr[18], nonce, PAD_WORD, 320'd0, LEN_640} :
                 first;
endmodule

// File: rtl/bitcoin_nonce_sched.sv
// bitcoin_nonce_sched: header load and double-SHA-256 schedule over a nonce sweep
module bitcoin_nonce_sched
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [15:0]                 message_addr,
  input  logic [15:0]                 output_addr,
  output logic                        done,
  bitcoin_nonce_sched_if.master       bus
);
  localparam int NW = $clog2(NUM_NONCES) + 1;
  state_t state, state_next;
  logic [4:0] wcnt;
  logic [NW-1:0] nonce, nonce_next;
  logic [HDR_WORDS-1:0][31:0] hdr;
  logic [255:0] midstate;
  logic [511:0] block;
  logic got, last, launch;
  assign got = bus.core_done && !bus.core_start;
  assign last = nonce == NW'(NUM_NONCES - 1);
  assign nonce_next = state == WRITE ? nonce + 1'b1 : nonce;
  assign launch = state_next != state && (state_next == MID || state_next == BLK1 || state_next == BLK2);
  assign done = state == IDLE;
  assign bus.mem_clk = clk;
  bitcoin_block_fmt u_fmt (
    .phase(state_next),
    .hdr(hdr),
    .nonce(32'(nonce_next)),
    .d1(bus.core_hout),
    .block(block)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  // phase sequencing; a core pass ends only on a done seen after its launch cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? READ : IDLE;
      READ:    state_next = wcnt == 5'(HDR_WORDS) ? MID : READ;
      MID:     state_next = got ? BLK1 : MID;
      BLK1:    state_next = got ? BLK2 : BLK1;
      BLK2:    state_next = got ? WRITE : BLK2;
      WRITE:   state_next = last ? IDLE : BLK1;
      default: state_next = IDLE;
    endcase
  end
  // header capture, core launch registers, midstate and result write-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
      nonce <= '0;
      hdr <= '0;
      midstate <= '0;
      bus.mem_addr <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_write_data <= '0;
      bus.core_start <= 1'b0;
      bus.core_hin <= '0;
      bus.core_block <= '0;
    end else begin
      bus.core_start <= launch;
      bus.mem_we <= state == BLK2 && got;
      if (launch) begin
        bus.core_block <= block;
        bus.core_hin <= state_next != BLK1 ? IV : state == MID ? bus.core_hout : midstate;
      end
      if (state == MID && got) midstate <= bus.core_hout;
      if (state == IDLE && start) begin
        wcnt <= '0;
        nonce <= '0;
        bus.mem_addr <= message_addr;
      end
      if (state == READ) begin
        wcnt <= wcnt + 1'b1;
        bus.mem_addr <= message_addr + 16'(wcnt) + 16'd1;
        if (wcnt != '0) hdr[wcnt - 1'b1] <= bus.mem_read_data;
      end
      if (state == BLK2 && got) begin
        bus.mem_addr <= output_addr + 16'(nonce);
        bus.mem_write_data <= bus.core_hout[255:224];
      end
      if (state == WRITE && !last) nonce <= nonce_next;
    end
  end
endmodule

// File: tb/tb_bitcoin_nonce_sched.sv
// tb_bitcoin_nonce_sched: table-driven runs against a software double-SHA-256 reference
module tb_bitcoin_nonce_sched;
  localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    int lat;
    logic [15:0] ma;
    logic [15:0] oa;
    bit disturb;
    bit blk_chk;
    bit fresh;
    int cycles;
    int pulses;
    int writes;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n, start, done, mdone, inj;
  logic [15:0] message_addr, output_addr;
  int lat_g = 64;
  int rem = 0;
  int stab_err = 0;
  int checks = 0;
  int errors = 0;
  logic [255:0] jhin, jres;
  logic [511:0] jblk;
  logic [31:0] mem [65536];
  logic [31:0] hdr_w [19];
  logic [31:0] exp_h0 [16];
  logic [15:0] wq_addr [$];
  logic [31:0] wq_data [$];
  logic [255:0] jq_hin [$];
  logic [511:0] jq_blk [$];
  vec_t tbl [5];

  bitcoin_nonce_sched_if bus ();
  bitcoin_nonce_sched #(.NUM_NONCES(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .message_addr(message_addr),
    .output_addr(output_addr),
    .done(done),
    .bus(bus.master)
  );

  always #5 clk = ~clk;
  assign bus.core_done = mdone | inj;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // full SHA-256 of a word-aligned message with standard padding
  function automatic logic [255:0] sha256(input logic [31:0] m [$]);
    int n = m.size();
    logic [255:0] h = SHA_IV;
    logic [511:0] b;
    m.push_back(32'h80000000);
    while (m.size() % 16 != 14) m.push_back(32'd0);
    m.push_back(32'd0);
    m.push_back(32'(n * 32));
    for (int i = 0; i < m.size(); i += 16) begin
      for (int j = 0; j < 16; j++) b[511-32*j -: 32] = m[i+j];
      h = sha_compress(h, b);
    end
    return h;
  endfunction

  function automatic logic [31:0] ref_h0(input int n);
    logic [31:0] m [$];
    logic [255:0] d;
    for (int k = 0; k < 19; k++) m.push_back(hdr_w[k]);
    m.push_back(32'(n));
    d = sha256(m);
    m.delete();
    for (int i = 0; i < 8; i++) m.push_back(d[255-32*i -: 32]);
    d = sha256(m);
    return d[255:224];
  endfunction

  function automatic int run_len(input int l);
    return 20 + (1 + l) + 16 * (2 * (1 + l) + 1);
  endfunction

  // memory: registered read, writes logged in order
  always @(posedge clk) begin
    bus.mem_read_data <= mem[bus.mem_addr];
    if (bus.mem_we) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_write_data);
    end
  end

  // SHA-256 core model: done lat_g cycles after the start cycle, inputs must hold meanwhile
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem = 0;
      mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (rem > 0 && (bus.core_block !== jblk || bus.core_hin !== jhin)) stab_err++;
      if (bus.core_start) begin
        jhin = bus.core_hin;
        jblk = bus.core_block;
        jres = sha_compress(jhin, jblk);
        rem = lat_g;
        jq_hin.push_back(jhin);
        jq_blk.push_back(jblk);
      end
      if (rem == 1) begin
        mdone <= 1'b1;
        bus.core_hout <= jres;
      end
      if (rem > 0) rem--;
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load_hdr(input bit fresh, input logic [15:0] ma);
    if (fresh) for (int k = 0; k < 19; k++) hdr_w[k] = $urandom;
    for (int k = 0; k < 19; k++) mem[ma + 16'(k)] = hdr_w[k];
    for (int n = 0; n < 16; n++) exp_h0[n] = ref_h0(n);
  endtask

  task automatic pulse_start(input logic [15:0] ma, input logic [15:0] oa);
    @(negedge clk);
    start = 1'b1;
    message_addr = ma;
    output_addr = oa;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input vec_t v, input string tag);
    int wb, jb, cnt;
    logic [15:0] ea;
    logic [511:0] b0;
    lat_g = v.lat;
    load_hdr(v.fresh, v.ma);
    wb = wq_data.size();
    jb = jq_blk.size();
    pulse_start(v.ma, v.oa);
    cnt = 0;
    while (!done && cnt < 8000) begin
      inj = v.disturb && cnt == 5;
      start = v.disturb && cnt == 480;
      cnt++;
      @(negedge clk);
    end
    inj = 1'b0;
    start = 1'b0;
    check({tag, " cycles"}, 512'(cnt), 512'(v.cycles));
    check({tag, " pulses"}, 512'(jq_blk.size() - jb), 512'(v.pulses));
    check({tag, " writes"}, 512'(wq_data.size() - wb), 512'(v.writes));
    for (int n = 0; n < 16; n++) if (wb + n < wq_data.size()) begin
      ea = v.oa + 16'(n);
      check($sformatf("%s waddr[%0d]", tag, n), 512'(wq_addr[wb+n]), 512'(ea));
      check($sformatf("%s wdata[%0d]", tag, n), 512'(wq_data[wb+n]), 512'(exp_h0[n]));
    end
    if (v.blk_chk && jq_blk.size() > jb + 12) begin
      for (int i = 0; i < 16; i++) b0[511-32*i -: 32] = hdr_w[i];
      check("blk1 hin midstate", 512'(jq_hin[jb+11]), 512'(sha_compress(SHA_IV, b0)));
      check("blk1 word2", 512'(jq_blk[jb+11][447:416]), 512'(hdr_w[18]));
      check("blk1 word3", 512'(jq_blk[jb+11][415:384]), 512'd5);
      check("blk1 word4", 512'(jq_blk[jb+11][383:352]), 512'h80000000);
      check("blk1 word15", 512'(jq_blk[jb+11][31:0]), 512'd640);
      check("blk2 word8", 512'(jq_blk[jb+12][255:224]), 512'h80000000);
      check("blk2 word15", 512'(jq_blk[jb+12][31:0]), 512'd256);
      check("blk2 hin", 512'(jq_hin[jb+12]), 512'(SHA_IV));
    end
    check({tag, " hold stable"}, 512'(stab_err), 512'd0);
  endtask

  initial begin
    int cnt, wb, l4;
    vec_t rv;
    reset_n = 1'b0;
    start = 1'b0;
    inj = 1'b0;
    message_addr = '0;
    output_addr = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset done", 512'(done), 512'd1);
    check("reset mem_we", 512'(bus.mem_we), 512'd0);
    check("reset core_start", 512'(bus.core_start), 512'd0);
    check("reset mem_addr", 512'(bus.mem_addr), 512'd0);
    check("reset wdata", 512'(bus.mem_write_data), 512'd0);
    check("reset core_hin", 512'(bus.core_hin), 512'd0);
    check("reset core_block", bus.core_block, 512'd0);
    l4 = $urandom_range(2, 9);
    tbl[0] = '{64, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b1, 2181, 33, 16};
    tbl[1] = '{1, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0, 102, 33, 16};
    tbl[2] = '{150, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0, 5019, 33, 16};
    tbl[3] = '{64, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0, 2181, 33, 16};
    tbl[4] = '{l4, 16'hfff5, 16'hfff8, 1'b0, 1'b1, 1'b1, run_len(l4), 33, 16};
    for (int i = 0; i < 5; i++) do_run(tbl[i], $sformatf("run%0d", i));
    lat_g = 64;
    load_hdr(1'b0, 16'h0000);
    wb = wq_data.size();
    pulse_start(16'h0000, 16'h0100);
    cnt = 0;
    while (!done && cnt < 1069) begin
      cnt++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("abort done", 512'(done), 512'd1);
    check("abort mem_we", 512'(bus.mem_we), 512'd0);
    check("abort core_start", 512'(bus.core_start), 512'd0);
    check("abort mem_addr", 512'(bus.mem_addr), 512'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort writes", 512'(wq_data.size() - wb), 512'd7);
    if (wq_addr.size() > 0) check("abort last addr", 512'(wq_addr[wq_addr.size()-1]), 512'h0106);
    rv = '{64, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b1, 2181, 33, 16};
    do_run(rv, "rerun");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitcoin_nonce_sched.md
# bitcoin_nonce_sched

Sequencing controller for the bitcoin-hash datapath. It loads a 19-word block header from the testbench memory and drives a single shared SHA-256 round core through the double-hash schedule: one midstate pass, then two core passes per nonce. It writes word H0 of each nonce's final digest back to memory. It sits between the memory port and the SHA-256 core and owns all block formatting and padding.

## Interface
- NUM_NONCES, default 16: nonces swept, 0..NUM_NONCES-1; legal range 1..256.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin run; sampled only in IDLE
- message_addr  in  16  word address of header word 0
- output_addr  in  16  word address for the nonce-0 result
- done  out  1  high whenever in IDLE
- mem_clk  out  1  equals clk
- mem_addr  out  16  memory word address
- mem_we  out  1  write enable
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data; valid 1 cycle after mem_addr
- core_start  out  1  one-cycle job launch pulse
- core_hin  out  256  initial hash; h0 in [255:224]
- core_block  out  512  message block; word 0 in [511:480]
- core_done  in  1  one-cycle pulse; core_hout valid that cycle
- core_hout  in  256  result digest; h0 in [255:224]

## Operation
- States: IDLE, READ, MID, BLK1, BLK2, WRITE.
- IDLE:
  - On start, clear the word and nonce counters and go to READ.
  - start in any other state is ignored.
- READ:
  - Present mem_addr = message_addr + k for k = 0..18 on consecutive cycles.
  - Capture mem_read_data one cycle later into hdr[k].
  - Go to MID after hdr[18] is captured; READ lasts 20 cycles.
- MID:
  - Launch core with hin = SHA-256 IV, block = hdr[0..15].
  - On core_done, store midstate = core_hout and go to BLK1.
- BLK1:
  - Launch with hin = midstate, block = {hdr[16], hdr[17], hdr[18], nonce, 32'h80000000, ten zero words, 32'd640}.
  - On core_done, store d1 = core_hout and go to BLK2.
- BLK2:
  - Launch with hin = IV, block = {d1 word0..7, 32'h80000000, six zero words, 32'd256}.
  - On core_done, go to WRITE.
- WRITE (one cycle):
  - mem_we = 1, mem_addr = output_addr + nonce, mem_write_data = core_hout[255:224] captured at BLK2 done.
  - If nonce == NUM_NONCES-1, go to IDLE.
  - Else nonce++ and go to BLK1. The midstate is reused, never recomputed.
- Arithmetic and widths:
  - Address adds are 16-bit and wrap modulo 2^16.
  - The nonce counter is $clog2(NUM_NONCES)+1 bits and is zero-extended to 32 bits in the block.

## Timing
- Reset values:
  - State IDLE.
  - done = 1, mem_we = 0, core_start = 0.
  - mem_addr = 0, mem_write_data = 0.
  - core_hin = 0, core_block = 0.
- Launch handshake:
  - core_start pulses for exactly one cycle, on the first cycle of MID, BLK1 and BLK2.
  - core_hin and core_block are registered. They are valid on the start cycle and held stable until core_done.
- core_done is honoured only while waiting in MID, BLK1 or BLK2 after launch. It is ignored in IDLE, READ and WRITE, and in the launch cycle itself.
- The core may take 1 to any number of cycles. The scheduler imposes no timeout.
- mem_we is high only in WRITE. It is low in READ.
- Run length = 20 + (1 + L) + NUM_NONCES × (2 × (1 + L) + 1) cycles, where L is the core latency in cycles from start to done.
- done falls the cycle after start is accepted. It rises the cycle after the last WRITE.
- reset_n asserted mid-run:
  - Immediate return to IDLE with all outputs at reset values.
  - No partial write completes.
  - Header and midstate are invalid; the next start reloads them.

## Structure
- Shared package bitcoin_pkg holds:
  - the state enum;
  - the SHA-256 IV (8 × 32);
  - PAD_WORD = 32'h80000000;
  - LEN_640 and LEN_256;
  - HDR_WORDS = 19.
- One natural sub-module: bitcoin_block_fmt. It is combinational. It maps (phase, hdr, nonce, d1) to core_block and lives beside the FSM. The FSM, header buffer and counters stay in bitcoin_nonce_sched.

## Test plan
- Reset, then idle 5 cycles → done = 1, mem_we = 0, core_start = 0, mem_addr = 0.
- Standard 19-word header at message_addr = 0, output_addr = 16'h0100, NUM_NONCES = 16, core model with L = 64 → 33 core_start pulses; 16 writes to 0x0100..0x010F; each value equals the software double-SHA H0 for its nonce.
- Capture core_block on the BLK1 and BLK2 launches of nonce 5 → BLK1: word3 = 5, word4 = 32'h80000000, word15 = 640. BLK2: word8 = 32'h80000000, word15 = 256, hin = IV.
- Pulse start during BLK1 of nonce 3, and pulse core_done during READ → no effect; pulse counts and written values are unchanged.
- Drop reset_n for 1 cycle during BLK2 of nonce 7 → done = 1 the next cycle; no write for nonce 7; a new start rereads the header and writes nonces 0..15 correctly.
- Repeat the standard run with L = 1 and then L = 150 → written results are identical to the L = 64 run; cycle count matches the run-length formula.
